// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for fifo_ip: pops an async-read FIFO into a two-entry
// output buffer with a registered valid/ready stream, packet last flag and beat count.
module fifo_rd_stream #(
  parameter int WordLength = 8,
  parameter int PktLen     = 4,
  parameter int CntBits    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  fifo_empty_i,
  input  logic [WordLength-1:0] fifo_data_i,
  output logic                  fifo_rd_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [WordLength-1:0] m_data_o,
  output logic                  m_last_o,
  output logic [CntBits-1:0]    beat_cnt_o
);

  localparam int IdxBits = (PktLen > 1) ? $clog2(PktLen) : 1;
  localparam logic [IdxBits-1:0] IdxLast = IdxBits'(PktLen - 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [WordLength-1:0] r_out;
  logic [WordLength-1:0] r_skid;
  logic [IdxBits-1:0]    r_idx;
  logic [CntBits-1:0]    r_cnt;

  logic w_valid;
  logic w_pop;
  logic w_take;
  logic w_load_out_fifo;
  logic w_load_out_skid;
  logic w_load_skid;

  assign w_valid = (r_state != ST_EMPTY);
  // The pop decision looks only at registered state, never at m_ready_i.
  assign w_pop   = en_i & ~fifo_empty_i & (r_state != ST_TWO) & ~rst_i;
  assign w_take  = w_valid & m_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_load_out_fifo = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_pop) begin
          w_load_out_fifo = 1'b1;
          w_state_next    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_pop && w_take) begin
          w_load_out_fifo = 1'b1;
        end else if (w_pop) begin
          w_load_skid  = 1'b1;
          w_state_next = ST_TWO;
        end else if (w_take) begin
          w_state_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_take) begin
          w_load_out_skid = 1'b1;
          w_state_next    = ST_ONE;
        end
      end
      default: begin
        w_state_next = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out  <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_out_fifo) begin
        r_out <= fifo_data_i;
      end else if (w_load_out_skid) begin
        r_out <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= fifo_data_i;
      end
    end
  end

  // Packet index and delivered-beat counter both advance on every take.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idx <= '0;
      r_cnt <= '0;
    end else if (w_take) begin
      r_cnt <= r_cnt + CntBits'(1);
      if (r_idx == IdxLast) begin
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + IdxBits'(1);
      end
    end
  end

  assign fifo_rd_o  = w_pop;
  assign m_valid_o  = w_valid;
  assign m_data_o   = r_out;
  assign m_last_o   = w_valid & (r_idx == IdxLast);
  assign beat_cnt_o = r_cnt;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO and buffer modelled as queues, three parameter sets.
module tb_fifo_rd_stream;

  logic       clk;
  logic       rst_i;
  logic       en_i;
  logic       fifo_empty_i;
  logic [7:0] fifo_data_i;
  logic       m_ready_i;

  logic        rd_a, valid_a, last_a;
  logic [7:0]  data_a;
  logic [15:0] cnt_a;
  logic        rd_b, valid_b, last_b;
  logic [7:0]  data_b;
  logic [15:0] cnt_b;
  logic        rd_c, valid_c, last_c;
  logic [7:0]  data_c;
  logic [3:0]  cnt_c;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] buf_q[$];
  int takes;

  fifo_rd_stream #(.WordLength(8), .PktLen(4), .CntBits(16)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .fifo_empty_i(fifo_empty_i),
    .fifo_data_i(fifo_data_i), .fifo_rd_o(rd_a), .m_valid_o(valid_a),
    .m_ready_i(m_ready_i), .m_data_o(data_a), .m_last_o(last_a), .beat_cnt_o(cnt_a)
  );

  fifo_rd_stream #(.WordLength(8), .PktLen(1), .CntBits(16)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .fifo_empty_i(fifo_empty_i),
    .fifo_data_i(fifo_data_i), .fifo_rd_o(rd_b), .m_valid_o(valid_b),
    .m_ready_i(m_ready_i), .m_data_o(data_b), .m_last_o(last_b), .beat_cnt_o(cnt_b)
  );

  fifo_rd_stream #(.WordLength(8), .PktLen(3), .CntBits(4)) dut_c (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .fifo_empty_i(fifo_empty_i),
    .fifo_data_i(fifo_data_i), .fifo_rd_o(rd_c), .m_valid_o(valid_c),
    .m_ready_i(m_ready_i), .m_data_o(data_c), .m_last_o(last_c), .beat_cnt_o(cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_data_i  = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
  endtask

  function automatic logic model_pop();
    return en_i && (fifo_q.size() != 0) && (buf_q.size() < 2) && !rst_i;
  endfunction

  task automatic check_all();
    logic exp_valid;
    logic exp_pop;
    exp_valid = (buf_q.size() != 0);
    exp_pop   = model_pop();
    chk("rd_a", 32'(rd_a), 32'(exp_pop));
    chk("rd_b", 32'(rd_b), 32'(exp_pop));
    chk("rd_c", 32'(rd_c), 32'(exp_pop));
    chk("valid_a", 32'(valid_a), 32'(exp_valid));
    chk("valid_b", 32'(valid_b), 32'(exp_valid));
    chk("valid_c", 32'(valid_c), 32'(exp_valid));
    if (exp_valid) begin
      chk("data_a", 32'(data_a), 32'(buf_q[0]));
      chk("data_b", 32'(data_b), 32'(buf_q[0]));
      chk("data_c", 32'(data_c), 32'(buf_q[0]));
    end
    chk("last_a", 32'(last_a), 32'(exp_valid && (takes % 4 == 3)));
    chk("last_b", 32'(last_b), 32'(exp_valid));
    chk("last_c", 32'(last_c), 32'(exp_valid && (takes % 3 == 2)));
    chk("cnt_a", 32'(cnt_a), takes % 65536);
    chk("cnt_b", 32'(cnt_b), takes % 65536);
    chk("cnt_c", 32'(cnt_c), takes % 16);
  endtask

  // One clock: drive at negedge, check, then advance the reference at posedge.
  task automatic cycle(input logic en, input logic rdy);
    logic do_pop;
    logic do_take;
    logic [7:0] word;
    en_i = en;
    m_ready_i = rdy;
    drive_fifo();
    #1;
    check_all();
    do_pop  = model_pop();
    do_take = (buf_q.size() != 0) && rdy;
    @(posedge clk);
    if (do_take) begin
      word = buf_q.pop_front();
      takes++;
      $display("beat %0d data=%02h last4=%0b", takes, word, ((takes - 1) % 4 == 3));
    end
    if (do_pop) buf_q.push_back(fifo_q.pop_front());
    @(negedge clk);
  endtask

  task automatic push_run(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + 8'(i));
  endtask

  initial begin
    rst_i = 1'b1;
    en_i = 1'b1;
    m_ready_i = 1'b1;
    takes = 0;
    fifo_q.push_back(8'h55);
    drive_fifo();
    @(negedge clk);
    @(negedge clk);
    #1;
    check_all();
    chk("rst_data", 32'(data_a), 32'h0);
    fifo_q.delete();
    rst_i = 1'b0;

    // Stream of 8 with ready held high.
    push_run(8'h10, 8);
    for (int i = 0; i < 11; i++) cycle(1'b1, 1'b1);
    chk("stream_cnt", 32'(cnt_a), 32'd8);

    // Backpressure: stall cycles 2..6.
    push_run(8'hA0, 6);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0);
      chk("stall_data", 32'(data_a), 32'hA0);
    end
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1);

    // Disable with two words buffered.
    push_run(8'hB0, 8);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1);

    // Empty FIFO, then one late word.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1);
    fifo_q.push_back(8'hC5);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);

    // Reach TWO with idx = 2, then reset between edges.
    rst_i = 1'b1;
    buf_q.delete();
    takes = 0;
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    push_run(8'hD0, 6);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    chk("pre_rst_valid", 32'(valid_a), 32'h1);
    #2;
    rst_i = 1'b1;
    buf_q.delete();
    takes = 0;
    drive_fifo();
    #1;
    check_all();
    @(posedge clk);
    @(negedge clk);
    #1;
    check_all();
    rst_i = 1'b0;

    // 17 takes: the 4-bit counter wraps to 1.
    fifo_q.delete();
    push_run(8'h40, 17);
    for (int i = 0; i < 19; i++) cycle(1'b1, 1'b1);
    chk("wrap_cnt4", 32'(cnt_c), 32'h1);
    chk("cnt_17", 32'(cnt_a), 32'd17);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 16) fifo_q.push_back(8'($urandom));
      cycle($urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain stage for `fifo_ip`. It pops words from the FIFO's asynchronous-read port and presents them on a registered valid/ready stream. A two-entry output buffer gives one word per cycle sustained throughput, and `fifo_rd_o` never depends combinationally on `m_ready_i`. The stage also frames the stream into fixed-length packets with a last flag and keeps a running count of delivered beats.

## Interface
- `WordLength`, default 8: data width; must match the `fifo_ip` instance.
- `PktLen`, default 4: beats per packet; legal values are 1 to 2^16.
- `CntBits`, default 16: width of the delivered-beat counter.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, asynchronous and active-high.
- `en_i` in 1: high allows new pops from the FIFO.
- `fifo_empty_i` in 1: the FIFO's `empty_o`.
- `fifo_data_i` in WordLength: the FIFO's `r_data_o`, valid in the same cycle (asynchronous read).
- `fifo_rd_o` out 1: drives the FIFO's `rd_i`; one pulse per pop.
- `m_valid_o` out 1: output word valid.
- `m_ready_i` in 1: downstream accepts the word.
- `m_data_o` out WordLength: output word.
- `m_last_o` out 1: output word is the final beat of a packet.
- `beat_cnt_o` out CntBits: total accepted beats, modulo 2^CntBits.

## Operation
- **Buffer**
  - The buffer is an output register (OUT) plus a skid register (SKID).
  - State is EMPTY, ONE (OUT valid) or TWO (OUT and SKID valid).
- **Event definitions**
  - `pop = en_i & ~fifo_empty_i & (state != TWO) & ~rst_i`.
  - `fifo_rd_o = pop`.
  - `take = m_valid_o & m_ready_i`.
- **Transitions**
  - EMPTY, pop: OUT <= fifo_data_i; next state ONE.
  - ONE, pop & take: OUT <= fifo_data_i; stay in ONE.
  - ONE, pop & ~take: SKID <= fifo_data_i; next state TWO.
  - ONE, ~pop & take: next state EMPTY.
  - ONE, neither: hold.
  - TWO, take: OUT <= SKID; next state ONE. No pop is possible in TWO.
  - TWO, ~take: hold.
- **Output**
  - `m_valid_o` = (state != EMPTY).
  - `m_data_o` = OUT.
  - While `m_valid_o & ~m_ready_i`, `m_data_o` and `m_last_o` must hold stable.
- **Ordering**: words leave in FIFO order. There is no loss or duplication.
- **Packet framing**
  - The beat index `idx` has width clog2(PktLen), minimum 1 bit.
  - `idx` increments on each take. It wraps to 0 after PktLen-1.
  - `m_last_o = m_valid_o & (idx == PktLen-1)`.
  - With PktLen = 1, `m_last_o` equals `m_valid_o`.
- **Beat counter**: `beat_cnt_o` increments by 1 on each take and wraps silently at 2^CntBits.
- **Disable**: while `en_i` is low, no pops occur. Buffered words still drain normally, and `idx` and `beat_cnt_o` are preserved.
- **FIFO empty**: `fifo_rd_o` stays low. An underflow pop is impossible.
- **Reset** (any time, including mid-packet):
  - state becomes EMPTY; `idx` = 0; `beat_cnt_o` = 0.
  - `m_valid_o` = 0, `m_last_o` = 0, `m_data_o` = 0.
  - `fifo_rd_o` = 0 combinationally while `rst_i` is high.
  - Buffered words are discarded.

## Timing
- `fifo_rd_o` is combinational from registered state plus `en_i`, `fifo_empty_i` and `rst_i`. It has no path from `m_ready_i`.
- Pop latency: a word popped in cycle N appears on `m_data_o` with `m_valid_o` high from cycle N+1.
- Throughput: with `m_ready_i` held high and the FIFO non-empty, one pop and one take occur every cycle. State stays ONE.
- Backpressure:
  - In the first stall cycle, a pop still lands in SKID.
  - Pops then stop until a take occurs.
  - After `m_ready_i` rises, the first take is in that same cycle and pops resume in the next cycle.
- `m_last_o`, `idx` and `beat_cnt_o` update on the clock edge of the take.
- Reset acts asynchronously on all registers. Release is synchronous to `clk_i`.

## Test plan
1. **Stream**: reset, then the FIFO holds 8, 0x10..0x17, with `m_ready_i`=1 and `en_i`=1.
   - `fifo_rd_o` is high for 8 consecutive cycles.
   - `m_data_o` shows 0x10..0x17 in consecutive cycles starting one cycle after the first pop.
   - `m_last_o` is high on 0x13 and 0x17; `beat_cnt_o` ends at 8.
2. **Backpressure**: FIFO holds 0xA0..0xA5; `m_ready_i`=0 for cycles 2-6.
   - State reaches TWO and `fifo_rd_o` stays low while in TWO.
   - `m_data_o` stays at 0xA0 for the whole stall.
   - After release, the output is 0xA0..0xA5 in order with no gaps or duplicates.
3. **Disable**: toggle `en_i` low mid-stream with 2 words buffered.
   - Exactly those 2 words drain and `fifo_rd_o` stays 0.
   - On re-enable, pops resume and `idx` continues, e.g. `m_last_o` falls on the 4th beat of the packet.
4. **Empty FIFO**: hold `fifo_empty_i`=1 for 10 cycles.
   - `fifo_rd_o` = 0 and `m_valid_o` = 0 throughout.
   - A single word arriving later appears exactly one cycle after its pop.
5. **Reset mid-packet**: assert `rst_i` asynchronously (between clock edges) in state TWO with `idx`=2.
   - `m_valid_o`, `fifo_rd_o`, `m_last_o` and `beat_cnt_o` are 0 immediately.
   - After release, the first delivered word has `idx` = 0.
6. **Parameter corners**:
   - PktLen = 1: `m_last_o` is high on every beat.
   - CntBits = 4 with 17 takes: `beat_cnt_o` wraps to 1.
